// File: rtl/saradc_pkg.sv
// rtl/saradc_pkg.sv - shared SAR ADC state encoding and default geometry
package saradc_pkg;

  // Default resolution and track time, shared with the analog macro wrapper.
  localparam int SARADC_NBITS = 8;
  localparam int SARADC_NSAMP = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CONV   = 2'd2,
    ST_DONE   = 2'd3
  } sar_state_e;

endpackage

// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - monotonic-switching SAR sequencer with start/done handshake
module saradc_sar_ctrl
  import saradc_pkg::*;
#(
  parameter int NBITS = SARADC_NBITS,
  parameter int NSAMP = SARADC_NSAMP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  output logic             BUSY,
  output logic             SAMPLE,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             VALID,
  input  logic             CMPO,
  output logic [NBITS-1:0] DOUT
);

  localparam int KW     = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SCNT_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam logic [KW-1:0]     K_MSB     = KW'(NBITS - 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(NSAMP - 1);

  sar_state_e        state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic              sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [NBITS-1:0]  rp_q, rp_d;
  logic [NBITS-1:0]  rn_q, rn_d;
  logic [NBITS-1:0]  dout_q, dout_d;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    k_d      = k_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    rp_d     = rp_q;
    rn_d     = rn_q;
    dout_d   = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_SAMPLE;
          scnt_d   = SCNT_LOAD;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          rp_d     = '0;
          rn_d     = '0;
        end
      end
      ST_SAMPLE: begin
        // Track phase lasts NSAMP cycles; the counter was loaded with NSAMP-1 on entry.
        if (scnt_q == '0) begin
          state_d  = ST_CONV;
          sample_d = 1'b0;
          k_d      = K_MSB;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      ST_CONV: begin
        // Monotonic switching: the comparator decision directly becomes bit k.
        rp_d[k_q] = CMPO;
        rn_d[k_q] = ~CMPO;
        if (k_q == '0) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          dout_d  = rp_d;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      ST_DONE: begin
        k_d = K_MSB;
        if (CONT) begin
          state_d  = ST_SAMPLE;
          scnt_d   = SCNT_LOAD;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          rp_d     = '0;
          rn_d     = '0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sample_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Single state register; asynchronous reset returns every output to zero immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      scnt_q   <= '0;
      k_q      <= K_MSB;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      rp_q     <= '0;
      rn_q     <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      k_q      <= k_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      rp_q     <= rp_d;
      rn_q     <= rn_d;
      dout_q   <= dout_d;
    end
  end

  assign BUSY    = busy_q;
  assign SAMPLE  = sample_q;
  assign VALID   = valid_q;
  assign RESULTP = rp_q;
  assign RESULTN = rn_q;
  assign DOUT    = dout_q;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb/tb_saradc_sar_ctrl.sv - directed table-driven bench for the SAR sequencer
module tb_saradc_sar_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic       cmpo;
  logic       busy;
  logic       sample;
  logic       valid;
  logic [7:0] resultp;
  logic [7:0] resultn;
  logic [7:0] dout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       start;
    logic       cont;
    logic       cmpo;
    logic       samp;
    logic       busy;
    logic       valid;
    logic [7:0] rp;
    logic [7:0] rn;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[13];

  saradc_sar_ctrl #(.NBITS(8), .NSAMP(2)) dut (
    .CLK    (clk),
    .RST    (rst),
    .START  (start),
    .CONT   (cont),
    .BUSY   (busy),
    .SAMPLE (sample),
    .RESULTP(resultp),
    .RESULTN(resultn),
    .VALID  (valid),
    .CMPO   (cmpo),
    .DOUT   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_excl(input string nm);
    chk(nm, {24'd0, resultp & resultn}, 32'd0);
  endtask

  initial begin
    logic [7:0] pat;

    // Test 1/2/3: CMPO 1,0,1,1,0,0,1,0 with stray START pulses and CMPO activity outside CONV.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h40, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA0, 8'h40, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB0, 8'h40, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB0, 8'h48, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB0, 8'h4C, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4C, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 8'h4D, 8'hB2};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D, 8'hB2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D, 8'hB2};

    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    cmpo  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {5'd0, sample, busy, valid, resultp, resultn, dout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {5'd0, sample, busy, valid, resultp, resultn, dout}, 32'd0);

    // Table: inputs applied on the falling edge, outputs checked on the next falling edge.
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start;
      cont  = vecs[i].cont;
      cmpo  = vecs[i].cmpo;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {5'd0, sample, busy, valid, resultp, resultn, dout},
          {5'd0, vecs[i].samp, vecs[i].busy, vecs[i].valid, vecs[i].rp, vecs[i].rn, vecs[i].dout});
      chk_excl($sformatf("vec%0d_pn_excl", i));
    end

    // START held high in IDLE: back-to-back conversions with one IDLE cycle between.
    start = 1'b1;
    cont  = 1'b0;
    cmpo  = 1'b0;
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      chk($sformatf("held_start_busy_c%0d", j), {31'd0, busy},
          {31'd0, (j <= 11 || (j >= 13 && j <= 23)) ? 1'b1 : 1'b0});
      chk($sformatf("held_start_valid_c%0d", j), {31'd0, valid},
          {31'd0, (j == 11 || j == 23) ? 1'b1 : 1'b0});
      if (j >= 23) start = 1'b0;
    end

    // Free-running: FF, 00, FF codes; CONT dropped in the third conversion's CONV phase.
    start = 1'b1;
    cont  = 1'b1;
    cmpo  = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("cont_busy_c%0d", j), {31'd0, busy}, {31'd0, (j <= 33) ? 1'b1 : 1'b0});
      chk($sformatf("cont_valid_c%0d", j), {31'd0, valid},
          {31'd0, (j == 11 || j == 22 || j == 33) ? 1'b1 : 1'b0});
      if (j == 11) chk("cont_dout1", {24'd0, dout}, 32'h0000_00FF);
      if (j == 22) chk("cont_dout2", {24'd0, dout}, 32'h0000_0000);
      if (j == 33) chk("cont_dout3", {24'd0, dout}, 32'h0000_00FF);
      chk_excl($sformatf("cont_pn_excl_c%0d", j));
      cmpo = (j <= 12 || j >= 23) ? 1'b1 : 1'b0;
      if (j == 26) cont = 1'b0;
    end

    // Asynchronous reset while resolving bit 4; DOUT currently holds FF.
    start = 1'b1;
    cmpo  = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_rp", {24'd0, resultp}, 32'h0000_00E0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {5'd0, sample, busy, valid, resultp, resultn, dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("post_reset_quiet_%0d", j), {30'd0, busy, valid}, 32'd0);
    end

    // Normal conversion after reset: code 0x5A.
    pat   = 8'h5A;
    start = 1'b1;
    cmpo  = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("after_rst_valid_c%0d", j), {31'd0, valid}, {31'd0, (j == 11) ? 1'b1 : 1'b0});
      if (j == 11) begin
        chk("after_rst_dout", {24'd0, dout}, 32'h0000_005A);
        chk("after_rst_rn", {24'd0, resultn}, 32'h0000_00A5);
      end
      cmpo = (j >= 3 && j <= 10) ? pat[10 - j] : 1'b0;
    end
    chk("after_rst_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
